// File: rtl/load_store_unit.sv
// MEM-stage load/store engine: req/gnt/rvalid data port, byte-lane steering, load extension.
// Define LSU_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT_CYCLES (bus_err_o strobe).
module load_store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ready_o,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  misaligned_o,
  output logic                  bus_err_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("load_store_unit: only DATA_WIDTH=32 is supported");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("load_store_unit: TIMEOUT_CYCLES must fit the 8-bit WAIT counter (1..255)");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t state_q, state_d;

  logic        is_byte, is_half, aligned, mem_op, accept, reject;
  logic        load_done, timeout;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  // Operand latched at accept, presented unchanged while the request is pending
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  a_lo_q;
  logic [29:0] word_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Unsupported funct3 encodings fall through to word width
  assign is_byte = (funct3_i[1:0] == 2'b00);
  assign is_half = (funct3_i[1:0] == 2'b01);
  assign aligned = is_byte | (is_half ? ~addr_i[0] : (addr_i[1:0] == 2'b00));
  assign mem_op  = valid_i & (mem_read_i | mem_write_i);
  assign accept  = (state_q == S_IDLE) & mem_op & aligned;
  assign reject  = (state_q == S_IDLE) & mem_op & ~aligned;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    be_d    = 4'b1111;
    wdata_d = wdata_i;
    if (is_byte) begin
      be_d    = 4'b0001 << addr_i[1:0];
      wdata_d = {4{wdata_i[7:0]}};
    end else if (is_half) begin
      be_d    = 4'b0011 << addr_i[1:0];
      wdata_d = {2{wdata_i[15:0]}};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_REQ;
      S_REQ:  if (dmem_gnt_i) state_d = we_q ? S_IDLE : S_WAIT;
      S_WAIT: if (dmem_rvalid_i || timeout) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign load_done = (state_q == S_WAIT) & dmem_rvalid_i;

  always_comb begin
    byte_sel = dmem_rdata_i[7:0];
    case (a_lo_q)
      2'd1:    byte_sel = dmem_rdata_i[15:8];
      2'd2:    byte_sel = dmem_rdata_i[23:16];
      2'd3:    byte_sel = dmem_rdata_i[31:24];
      default: byte_sel = dmem_rdata_i[7:0];
    endcase
    half_sel = a_lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rd_valid_o   <= 1'b0;
      misaligned_o <= 1'b0;
      rd_data_o    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      rd_valid_o   <= load_done;
      misaligned_o <= reject;
      if (load_done)
        rd_data_o <= load_ext;
      else if (reject && !mem_write_i)
        rd_data_o <= '0;
    end
  end

  // NOTE: operand registers carry no reset; nothing observes them until an accept has loaded them.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= mem_write_i;
      funct3_q <= funct3_i;
      a_lo_q   <= addr_i[1:0];
      word_q   <= addr_i[31:2];
      be_q     <= be_d;
      wdata_q  <= wdata_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] wait_cnt_q;

  assign timeout = (state_q == S_WAIT) & ~dmem_rvalid_i &
                   (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // Counter is held at zero outside WAIT, so it starts from zero on every WAIT entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= 8'd0;
      bus_err_o  <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == S_WAIT) ? wait_cnt_q + 8'd1 : 8'd0;
      bus_err_o  <= timeout;
    end
  end
`else
  assign timeout   = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  assign ready_o      = (state_q == S_IDLE);
  assign stall_o      = ~ready_o | mem_op;
  assign dmem_req_o   = (state_q == S_REQ);
  assign dmem_we_o    = dmem_req_o & we_q;
  assign dmem_addr_o  = dmem_req_o ? {word_q, 2'b00} : '0;
  assign dmem_be_o    = dmem_req_o ? be_q : 4'b0000;
  assign dmem_wdata_o = dmem_req_o ? wdata_q : '0;

endmodule
